// File: rtl/iceyntese_pkg.sv
// Shared types and constants for the framed audio UART path.
package iceyntese_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DONE
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: owns bit timing and the shift register.
// A start presented in the last cycle of a stop bit chains the next byte with no idle gap.
module uart_tx_byte import iceyntese_pkg::*; #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] byte_in,
  input  logic                      start,
  output logic                      tx,
  output logic                      done_pulse
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] STOP_IDX = 4'(UART_DATA_BITS + 1);

  logic [UART_DATA_BITS:0] r_shift;
  logic [CNT_W-1:0]        r_clkCnt;
  logic [3:0]              r_bitIdx;
  logic                    r_active;
  logic                    r_tx;
  logic                    w_bitEnd;
  logic                    w_lastBit;

  assign w_bitEnd   = r_active && (r_clkCnt == LAST_CLK);
  assign w_lastBit  = w_bitEnd && (r_bitIdx == STOP_IDX);
  assign done_pulse = w_lastBit;
  assign tx         = r_tx;

  // r_shift holds the data bits still to go with the stop bit parked in the MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx     <= 1'b1;
      r_active <= 1'b0;
      r_clkCnt <= '0;
      r_bitIdx <= '0;
      r_shift  <= '1;
    end else if (start && (!r_active || w_lastBit)) begin
      r_tx     <= 1'b0;
      r_active <= 1'b1;
      r_clkCnt <= '0;
      r_bitIdx <= '0;
      r_shift  <= {1'b1, byte_in};
    end else if (r_active) begin
      if (w_bitEnd) begin
        r_clkCnt <= '0;
        r_bitIdx <= r_bitIdx + 4'd1;
        r_tx     <= r_shift[0];
        r_shift  <= {1'b1, r_shift[UART_DATA_BITS:1]};
        if (w_lastBit) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end
      end else begin
        r_clkCnt <= r_clkCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_frame_streamer.sv
// Frame sequencer: header byte, then each sample MSB byte first, channel 0 first.
// Define UART_FRAME_CSUM_EN to append an XOR checksum of the payload bytes.
module uart_frame_streamer import iceyntese_pkg::*; #(
  parameter int         CLKS_PER_BIT = 10,
  parameter int         NUM_CH       = 2,
  parameter int         SAMPLE_W     = 16,
  parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*SAMPLE_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [15:0]                frame_cnt
);

  localparam int BPS   = (SAMPLE_W + 7) / 8;
  localparam int EXT_W = 8 * BPS;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BI_W  = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [BI_W-1:0] FIRST_BYTE = BI_W'(BPS - 1);

  state_t                     r_state;
  state_t                     w_nextState;
  logic [NUM_CH*SAMPLE_W-1:0] r_data;
  logic [CH_W-1:0]            r_ch;
  logic [BI_W-1:0]            r_byte;
  logic                       r_last;
  logic                       r_kick;
  logic [15:0]                r_frameCnt;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]                 r_csum;
`endif
  logic                       w_accept;
  logic                       w_start;
  logic                       w_txDone;
  logic                       w_loadData;
  logic                       w_ptrLast;
  logic [SAMPLE_W-1:0]        w_sample;
  logic [EXT_W-1:0]           w_sampleExt;
  logic [7:0]                 w_dataByte;
  logic [7:0]                 w_byteIn;

  assign s_ready   = (r_state == IDLE) && !rst;
  assign w_accept  = s_valid && s_ready;
  assign busy      = (r_state != IDLE);
  assign frame_cnt = r_frameCnt;
  assign w_ptrLast = (r_ch == LAST_CH) && (r_byte == '0);

  // r_ch/r_byte always point at the next payload byte to hand to the transmitter
  always_comb begin
    w_sample = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_ch == CH_W'(c)) w_sample = r_data[c*SAMPLE_W +: SAMPLE_W];
    end
    w_sampleExt = EXT_W'(w_sample);
    w_dataByte  = '0;
    for (int b = 0; b < BPS; b++) begin
      if (r_byte == BI_W'(b)) w_dataByte = w_sampleExt[b*8 +: 8];
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_byteIn    = HEADER;
    w_loadData  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = HDR;
      end
      HDR: begin
        if (r_kick) begin
          w_start = 1'b1;
        end else if (w_txDone) begin
          w_start     = 1'b1;
          w_byteIn    = w_dataByte;
          w_loadData  = 1'b1;
          w_nextState = DATA;
        end
      end
      DATA: begin
        if (w_txDone) begin
          if (r_last) begin
`ifdef UART_FRAME_CSUM_EN
            w_start     = 1'b1;
            w_byteIn    = r_csum;
            w_nextState = CSUM;
`else
            w_nextState = DONE;
`endif
          end else begin
            w_start    = 1'b1;
            w_byteIn   = w_dataByte;
            w_loadData = 1'b1;
          end
        end
      end
`ifdef UART_FRAME_CSUM_EN
      CSUM: begin
        if (w_txDone) w_nextState = DONE;
      end
`endif
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // r_kick launches the header one cycle after acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_ch       <= '0;
      r_byte     <= '0;
      r_last     <= 1'b0;
      r_kick     <= 1'b0;
      r_frameCnt <= '0;
`ifdef UART_FRAME_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state <= w_nextState;
      r_kick  <= w_accept;
      if (w_accept) begin
        r_data <= s_data;
        r_ch   <= '0;
        r_byte <= FIRST_BYTE;
        r_last <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
        r_csum <= '0;
`endif
      end else if (w_loadData) begin
`ifdef UART_FRAME_CSUM_EN
        r_csum <= r_csum ^ w_dataByte;
`endif
        if (w_ptrLast) begin
          r_last <= 1'b1;
        end else if (r_byte == '0) begin
          r_byte <= FIRST_BYTE;
          r_ch   <= r_ch + 1'b1;
        end else begin
          r_byte <= r_byte - 1'b1;
        end
      end
      if (r_state == DONE) r_frameCnt <= r_frameCnt + 16'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_txByte (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (w_byteIn),
    .start     (w_start),
    .tx        (tx),
    .done_pulse(w_txDone)
  );

endmodule

// File: tb/tb_uart_frame_streamer.sv
// Directed bench for uart_frame_streamer: two instances (2x12-bit @4 clk/bit, 1x8-bit @2 clk/bit).
// Expected bytes include the checksum byte when UART_FRAME_CSUM_EN is defined.
module tb_uart_frame_streamer;

  localparam int CPB1 = 4;
  localparam int CPB2 = 2;

  logic        clk;
  logic        rst;
  logic [23:0] sData1;
  logic        sValid1, sReady1, tx1, busy1;
  logic [15:0] frameCnt1;
  logic [7:0]  sData2;
  logic        sValid2, sReady2, tx2, busy2;
  logic [15:0] frameCnt2;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] expBytes[$];

  uart_frame_streamer #(.CLKS_PER_BIT(CPB1), .NUM_CH(2), .SAMPLE_W(12), .HEADER(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .s_data(sData1), .s_valid(sValid1), .s_ready(sReady1),
    .tx(tx1), .busy(busy1), .frame_cnt(frameCnt1)
  );

  uart_frame_streamer #(.CLKS_PER_BIT(CPB2), .NUM_CH(1), .SAMPLE_W(8), .HEADER(8'hA5)) dut2 (
    .clk(clk), .rst(rst), .s_data(sData2), .s_valid(sValid2), .s_ready(sReady2),
    .tx(tx2), .busy(busy2), .frame_cnt(frameCnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic getTx(input int sel);
    return (sel == 1) ? tx1 : tx2;
  endfunction

  function automatic logic getBusy(input int sel);
    return (sel == 1) ? busy1 : busy2;
  endfunction

  function automatic logic getReady(input int sel);
    return (sel == 1) ? sReady1 : sReady2;
  endfunction

  function automatic logic [15:0] getCnt(input int sel);
    return (sel == 1) ? frameCnt1 : frameCnt2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offers a frame, waits for the accepting edge and checks the handshake response
  task automatic applyStimulus(input int sel, input logic [23:0] data, input bit keepValid);
    if (sel == 1) begin
      sData1  = data;
      sValid1 = 1'b1;
    end else begin
      sData2  = data[7:0];
      sValid2 = 1'b1;
    end
    @(posedge clk); #1;
    checkOutput("accept busy", 32'(getBusy(sel)), 32'd1);
    checkOutput("accept s_ready", 32'(getReady(sel)), 32'd0);
    checkOutput("accept tx still idle", 32'(getTx(sel)), 32'd1);
    if (!keepValid) begin
      if (sel == 1) sValid1 = 1'b0;
      else          sValid2 = 1'b0;
    end
  endtask

  // Samples tx every cycle from the edge after acceptance through DONE and back to IDLE
  task automatic checkFrame(input int sel, input int cpb, input logic [15:0] cntBefore);
    int         total, lineErr, readyErr, busyErr, k, bitPos, c;
    logic       line, expLine;
    logic [7:0] cur;
    logic [7:0] rx [0:7];
    logic [15:0] cntAfter;
    total    = expBytes.size() * 10 * cpb;
    lineErr  = 0;
    readyErr = 0;
    busyErr  = 0;
    for (int i = 0; i < 8; i++) rx[i] = 8'h00;
    for (int i = 0; i < total; i++) begin
      @(posedge clk); #1;
      k      = i / (10 * cpb);
      bitPos = (i / cpb) % 10;
      c      = i % cpb;
      cur    = expBytes[k];
      line   = getTx(sel);
      if (bitPos == 0)      expLine = 1'b0;
      else if (bitPos == 9) expLine = 1'b1;
      else                  expLine = cur[bitPos-1];
      if (line !== expLine) lineErr++;
      if (c == cpb / 2 && bitPos >= 1 && bitPos <= 8) rx[k][bitPos-1] = line;
      if (getReady(sel) !== 1'b0) readyErr++;
      if (getBusy(sel) !== 1'b1) busyErr++;
    end
    checkOutput("line bit timing errors", 32'(lineErr), 32'd0);
    for (int i = 0; i < expBytes.size(); i++) begin
      checkOutput($sformatf("rx byte %0d", i), 32'(rx[i]), 32'(expBytes[i]));
    end
    checkOutput("s_ready low in frame", 32'(readyErr), 32'd0);
    checkOutput("busy high in frame", 32'(busyErr), 32'd0);
    @(posedge clk); #1;
    checkOutput("done busy", 32'(getBusy(sel)), 32'd1);
    checkOutput("done tx idle", 32'(getTx(sel)), 32'd1);
    checkOutput("done frame_cnt", 32'(getCnt(sel)), 32'(cntBefore));
    cntAfter = cntBefore + 16'd1;
    @(posedge clk); #1;
    checkOutput("idle busy", 32'(getBusy(sel)), 32'd0);
    checkOutput("idle s_ready", 32'(getReady(sel)), 32'd1);
    checkOutput("idle frame_cnt", 32'(getCnt(sel)), 32'(cntAfter));
  endtask

  initial begin
    rst     = 1'b1;
    sValid1 = 1'b0;
    sValid2 = 1'b0;
    sData1  = '0;
    sData2  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset tx", 32'(tx1), 32'd1);
    checkOutput("reset s_ready", 32'(sReady1), 32'd0);
    checkOutput("reset busy", 32'(busy1), 32'd0);
    checkOutput("reset frame_cnt", 32'(frameCnt1), 32'd0);
    checkOutput("reset tx2", 32'(tx2), 32'd1);
    checkOutput("reset s_ready2", 32'(sReady2), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset s_ready", 32'(sReady1), 32'd1);
    checkOutput("post-reset s_ready2", 32'(sReady2), 32'd1);

    // Reset during the third byte aborts the frame without counting it
    applyStimulus(1, {12'h123, 12'hABC}, 1'b0);
    repeat (1 + 2 * 10 * CPB1 + 2 * CPB1) @(posedge clk);
    @(negedge clk);
    checkOutput("mid-frame busy", 32'(busy1), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort tx", 32'(tx1), 32'd1);
    checkOutput("abort busy", 32'(busy1), 32'd0);
    checkOutput("abort frame_cnt", 32'(frameCnt1), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("after abort tx", 32'(tx1), 32'd1);
    checkOutput("after abort s_ready", 32'(sReady1), 32'd1);

    // Basic frame; s_data changes after acceptance must not leak into the frame
    expBytes = '{8'hA5, 8'h0A, 8'hBC, 8'h01, 8'h23};
`ifdef UART_FRAME_CSUM_EN
    expBytes.push_back(8'h94);
`endif
    applyStimulus(1, {12'h123, 12'hABC}, 1'b0);
    sData1 = 24'hFFFFFF;
    checkFrame(1, CPB1, 16'd0);

    // s_valid held high across two back-to-back frames
    expBytes = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'hFF};
`ifdef UART_FRAME_CSUM_EN
    expBytes.push_back(8'h0F);
`endif
    applyStimulus(1, {12'h0FF, 12'hFFF}, 1'b1);
    checkFrame(1, CPB1, 16'd1);
    applyStimulus(1, {12'h0FF, 12'hFFF}, 1'b0);
    checkFrame(1, CPB1, 16'd2);

    // frame_cnt wrap
    @(negedge clk) force dut1.r_frameCnt = 16'hFFFF;
    @(negedge clk) release dut1.r_frameCnt;
    @(negedge clk);
    checkOutput("preset frame_cnt", 32'(frameCnt1), 32'h0000FFFF);
    expBytes = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00};
`ifdef UART_FRAME_CSUM_EN
    expBytes.push_back(8'h01);
`endif
    applyStimulus(1, {12'h000, 12'h001}, 1'b0);
    checkFrame(1, CPB1, 16'hFFFF);

    // Single 8-bit channel at the minimum bit period
    expBytes = '{8'hA5, 8'h00};
`ifdef UART_FRAME_CSUM_EN
    expBytes.push_back(8'h00);
`endif
    applyStimulus(2, 24'h000000, 1'b0);
    checkFrame(2, CPB2, 16'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
